lfsr_rng_gen: RTL
=================

LFSR_RNG_GEN -- requirements
Module: lfsr_rng_gen

Interface
REQ-001 Parameter: WIDTH, default 16, LFSR and output width; legal range 3..32.
REQ-002 Parameter: TAPS, default 16'hB400, feedback polynomial mask; bit WIDTH-1 SHALL be set.
REQ-003 Parameter: MODE, default 0, 0 = Fibonacci (XOR-feedback into LSB), 1 = Galois (masked XOR on MSB out).
REQ-004 Parameter: SEED, default 1, reset and fallback seed; SHALL be non-zero.
REQ-005 Parameter: SAMPLE_EVERY, default WIDTH, shifts per output sample; legal range 1..255.
REQ-006 clock  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  advance LFSR one step this cycle.
REQ-009 seed_load  input  1  load seed_in into LFSR this cycle.
REQ-010 seed_in  input  WIDTH  runtime seed value.
REQ-011 rnd_valid  output  1  rnd_data holds an unconsumed sample.
REQ-012 rnd_ready  input  1  consumer accepts sample when rnd_valid=1.
REQ-013 rnd_data  output  WIDTH  registered random sample.
REQ-014 overrun  output  1  sticky: a sample was dropped.

Function
REQ-015 Fibonacci step SHALL be state_next = {state[WIDTH-2:0], ^(state & TAPS)}.
REQ-016 Galois step SHALL be state_next = {state[WIDTH-2:0],1'b0} ^ (state[WIDTH-1] ? TAPS : 0).
REQ-017 LFSR SHALL step exactly once per cycle with enable=1 and seed_load=0; it holds otherwise.
REQ-018 seed_load=1 SHALL take priority over enable: state <= seed_in, or SEED when seed_in==0; shift counter <= 0; rnd_data, rnd_valid and overrun unchanged.
REQ-019 Shift counter (8 bits) SHALL increment on each step and wrap to 0 on the step where it equals SAMPLE_EVERY-1; that step is the sample step.
REQ-020 On a sample step, state_next SHALL be captured into rnd_data the same edge the LFSR updates; rnd_valid rises the following cycle (latency 1 clock from the sample-step edge).
REQ-021 Transfer occurs when rnd_valid=1 and rnd_ready=1 at a rising edge; rnd_valid then clears unless a sample step occurs on the same edge.
REQ-022 Sample step with rnd_valid=1 and rnd_ready=0: new sample SHALL be discarded, rnd_data held stable, overrun <= 1.
REQ-023 Sample step with transfer on the same edge: new sample loaded, rnd_valid stays 1, no overrun.
REQ-024 rnd_data SHALL not change while rnd_valid=1 and rnd_ready=0.
REQ-025 overrun SHALL clear only on reset.
REQ-026 The all-zero state is unreachable; if detected (e.g. SEU), the next enabled step SHALL reload SEED instead of shifting.
REQ-027 rnd_ready SHALL be ignored while rnd_valid=0.

Reset
REQ-028 On reset=1 at a rising edge: state <= SEED, counter <= 0, rnd_data <= 0, rnd_valid <= 0, overrun <= 0; reset overrides seed_load and enable.
REQ-029 Reset mid-sample-window SHALL discard partial count; next sample after SAMPLE_EVERY further steps.

Verification
REQ-030 WIDTH=4, TAPS=4'hC, MODE=0, SEED=1, enable=1, SAMPLE_EVERY=1 -> state sequence 2,4,9,3,6,D,A,5,B,... and returns to 1 after exactly 15 steps.
REQ-031 Same config, SAMPLE_EVERY=4, rnd_ready=1 -> rnd_data samples 3 then 5, each rnd_valid pulse one cycle wide.
REQ-032 SAMPLE_EVERY=4, rnd_ready=0 for 8 steps -> rnd_data stays 3, overrun=1 after 8th step; rnd_ready=1 then -> one transfer, rnd_valid drops.
REQ-033 seed_load=1, seed_in=0, enable=1 -> state=SEED next cycle, no step taken, counter restarts at 0.
REQ-034 MODE=1, WIDTH=4, TAPS=4'h9, SEED=1 -> period 15 with no zero state; force state=0 -> next step loads SEED.
REQ-035 reset asserted during rnd_valid=1 with overrun=1 -> all outputs 0 next cycle, sequence restarts from SEED.

Source files
------------

// File: rtl/lfsr_rng_gen.sv
// Purpose: Fibonacci/Galois LFSR random generator that emits one sample every SAMPLE_EVERY steps.
// Latency: rnd_valid rises 1 clock after the sample-step edge; rnd_data is captured on that same edge.
// Backpressure: valid/ready; a sample that arrives while the held one is unconsumed is dropped and overrun sticks.
module lfsr_rng_gen #(
    parameter int              WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS        = WIDTH'(16'hB400),
    parameter int              MODE         = 0,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
    parameter int              SAMPLE_EVERY = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic [WIDTH-1:0] rnd_data,
    output logic             overrun
);

    localparam logic [7:0] CNT_LAST = 8'(SAMPLE_EVERY - 1);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] step_val;
    logic [7:0]       cnt;
    logic             do_step;
    logic             sample_step;
    logic             xfer;

    // An all-zero state would lock up the register, so treat it as a request to reseed.
    always_comb begin
        step_val = SEED;
        if (state != '0) begin
            if (MODE == 0) begin
                step_val = {state[WIDTH-2:0], ^(state & TAPS)};
            end else begin
                step_val = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? TAPS : '0);
            end
        end
    end

    assign do_step     = enable && !seed_load;
    assign sample_step = do_step && (cnt == CNT_LAST);
    assign xfer        = rnd_valid && rnd_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SEED;
            cnt       <= '0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (seed_load) begin
                state <= (seed_in == '0) ? SEED : seed_in;
                cnt   <= '0;
            end else if (enable) begin
                state <= step_val;
                cnt   <= sample_step ? 8'd0 : cnt + 8'd1;
            end

            // A fresh sample may replace the held one only if the slot is empty or draining this edge.
            if (sample_step && (!rnd_valid || xfer)) begin
                rnd_data  <= step_val;
                rnd_valid <= 1'b1;
            end else if (xfer) begin
                rnd_valid <= 1'b0;
            end

            if (sample_step && rnd_valid && !rnd_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
